// File: rtl/stavka_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stavka_pkg
//  Description : Shared widths, data types and opcodes for the stavka_c unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package stavka_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [2:0]        op_t;

    localparam op_t OP_HOLD = 3'b000;
    localparam op_t OP_LOAD = 3'b001;
    localparam op_t OP_CLR  = 3'b010;
    localparam op_t OP_SHL  = 3'b011;
    localparam op_t OP_SHR  = 3'b100;
    localparam op_t OP_ROL  = 3'b101;
    localparam op_t OP_ROR  = 3'b110;
    localparam op_t OP_DBL  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/stavka_c_if.sv
`default_nettype none
// ============================================================================
//  Module      : stavka_c_if
//  Description : Operand/opcode inputs and observed result/count of stavka_c.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stavka_c_if;
    import stavka_pkg::*;

    data_t data_in;
    op_t   control;
    data_t data_out;
    cnt_t  counter;

    modport master (
        output data_in,
        output control,
        input  data_out,
        input  counter
    );

    modport slave (
        input  data_in,
        input  control,
        output data_out,
        output counter
    );

endinterface
`default_nettype wire

// File: rtl/stavka_c_alu.sv
`default_nettype none
// ============================================================================
//  Module      : stavka_c_alu
//  Description : Combinational next-word selection and count-enable decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module stavka_c_alu
    import stavka_pkg::*;
(
    input  wire data_t i_q,
    input  wire data_t i_d,
    input  wire op_t   i_control,
    output data_t      o_next_q,
    output logic       o_counts
);

    always_comb begin
        o_next_q = i_q;
        // Every opcode except HOLD counts, even when the word does not change.
        o_counts = (i_control != OP_HOLD);
        case (i_control)
            OP_HOLD: o_next_q = i_q;
            OP_LOAD: o_next_q = i_d;
            OP_CLR:  o_next_q = '0;
            OP_SHL:  o_next_q = {i_q[2:0], 1'b0};
            OP_SHR:  o_next_q = {1'b0, i_q[3:1]};
            OP_ROL:  o_next_q = {i_q[2:0], i_q[3]};
            OP_ROR:  o_next_q = {i_q[0], i_q[3:1]};
            OP_DBL:  o_next_q = {i_d[2:0], 1'b0};
            default: o_next_q = i_q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stavka_c.sv
`default_nettype none
// ============================================================================
//  Module      : stavka_c
//  Description : Registered 4-bit shift/double unit with 8-bit op counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module stavka_c
    import stavka_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    stavka_c_if.slave  bus
);

    data_t r_q;
    cnt_t  r_cnt;
    data_t w_next_q;
    logic  w_counts;

    stavka_c_alu u_alu (
        .i_q       (r_q),
        .i_d       (bus.data_in),
        .i_control (bus.control),
        .o_next_q  (w_next_q),
        .o_counts  (w_counts)
    );

    // Reset wins over any opcode presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            r_q <= w_next_q;
            if (w_counts) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.data_out = r_q;
    assign bus.counter  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stavka_c.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stavka_c
//  Description : Self-checking bench for stavka_c (vector table + reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stavka_c;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    // Reference state, tracked as plain integers.
    int   m_q;
    int   m_cnt;

    stavka_c_if bus ();

    stavka_c dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] ctl;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl [14];

    // Word transform written as arithmetic on an integer in 0..15.
    function automatic int model_next(input int q, input int d, input int op);
        int r;
        r = q;
        if (op == 1)      r = d;
        else if (op == 2) r = 0;
        else if (op == 3) r = (q * 2) % 16;
        else if (op == 4) r = q / 2;
        else if (op == 5) r = (q * 2) % 16 + q / 8;
        else if (op == 6) r = q / 2 + (q % 2) * 8;
        else if (op == 7) r = (d * 2) % 16;
        return r;
    endfunction

    task automatic step(input logic r, input logic [2:0] ctl, input logic [3:0] d);
        @(negedge clk);
        rst          = r;
        bus.control  = ctl;
        bus.data_in  = d;
        @(posedge clk);
        if (r) begin
            m_q   = 0;
            m_cnt = 0;
        end else begin
            m_q = model_next(m_q, int'(d), int'(ctl));
            if (ctl != 3'b000) m_cnt = (m_cnt + 1) % 256;
        end
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] exp_q, input logic [7:0] exp_cnt);
        n_vec++;
        if (bus.data_out !== exp_q || bus.counter !== exp_cnt) begin
            n_err++;
            $display("FAIL %s: q=%h cnt=%h, required q=%h cnt=%h",
                     name, bus.data_out, bus.counter, exp_q, exp_cnt);
        end
    endtask

    task automatic check_model(input string name);
        check(name, 4'(m_q), 8'(m_cnt));
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        m_q         = 0;
        m_cnt       = 0;
        rst         = 1'b1;
        bus.control = 3'b000;
        bus.data_in = 4'h0;

        tbl[0]  = '{1'b1, 3'b101, 4'hF, 4'h0, 8'd0};
        tbl[1]  = '{1'b1, 3'b001, 4'h5, 4'h0, 8'd0};
        tbl[2]  = '{1'b0, 3'b000, 4'h7, 4'h0, 8'd0};
        tbl[3]  = '{1'b0, 3'b000, 4'h3, 4'h0, 8'd0};
        tbl[4]  = '{1'b0, 3'b000, 4'hC, 4'h0, 8'd0};
        tbl[5]  = '{1'b0, 3'b001, 4'b1011, 4'b1011, 8'd1};
        tbl[6]  = '{1'b0, 3'b011, 4'h0, 4'b0110, 8'd2};
        tbl[7]  = '{1'b0, 3'b100, 4'h0, 4'b0011, 8'd3};
        tbl[8]  = '{1'b0, 3'b101, 4'h0, 4'b0110, 8'd4};
        tbl[9]  = '{1'b0, 3'b110, 4'h0, 4'b0011, 8'd5};
        tbl[10] = '{1'b0, 3'b110, 4'h0, 4'b1001, 8'd6};
        tbl[11] = '{1'b0, 3'b111, 4'b1101, 4'b1010, 8'd7};
        tbl[12] = '{1'b0, 3'b010, 4'hF, 4'b0000, 8'd8};
        tbl[13] = '{1'b0, 3'b011, 4'hF, 4'b0000, 8'd9};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].ctl, tbl[i].d);
            check($sformatf("table[%0d]", i), tbl[i].exp_q, tbl[i].exp_cnt);
        end

        // Counter wrap: 255 loads reach FF, the next counted op wraps to 00.
        step(1'b1, 3'b000, 4'h0);
        check("wrap_reset", 4'h0, 8'h00);
        for (int i = 0; i < 255; i++) begin
            step(1'b0, 3'b001, 4'($urandom_range(0, 15)));
        end
        check("wrap_ff", 4'(m_q), 8'hFF);
        step(1'b0, 3'b010, 4'h9);
        check("wrap_00", 4'h0, 8'h00);

        // Reset priority with a count of 37 built up by random counted ops.
        step(1'b1, 3'b000, 4'h0);
        for (int i = 0; i < 37; i++) begin
            step(1'b0, 3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)));
        end
        check("cnt37", 4'(m_q), 8'd37);
        step(1'b1, 3'b011, 4'hA);
        check("rst_priority", 4'h0, 8'h00);

        // Randomised run against the reference model, with occasional resets.
        for (int i = 0; i < 100; i++) begin
            step(($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)));
            check_model($sformatf("random[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
